// File: rtl/s_aes_iter_ctrl.sv
// Iterative S-AES encrypt/decrypt controller with a shared round datapath.
// Ports: clk, rst (async, active-high); in_valid/in_ready with data_in,
//   key_in and encrypt; out_valid/out_ready with data_out; busy.

// GF(2^4) MixColumns over two 8-bit columns, polynomial x^4+x+1.
// Ports: encrypt selects MC (1) or IMC (0); data_in -> data_out.
module mix_columns (
    input  logic        encrypt,
    input  logic [15:0] data_in,
    output logic [15:0] data_out
);

    function automatic logic [3:0] xt(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] m2(input logic [3:0] a);
        return xt(a);
    endfunction

    function automatic logic [3:0] m4(input logic [3:0] a);
        return xt(xt(a));
    endfunction

    function automatic logic [3:0] m9(input logic [3:0] a);
        return xt(xt(xt(a))) ^ a;
    endfunction

    function automatic logic [7:0] col(input logic enc, input logic [7:0] c);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = c[7:4];
        lo = c[3:0];
        if (enc)
            return {hi ^ m4(lo), m4(hi) ^ lo};
        return {m9(hi) ^ m2(lo), m2(hi) ^ m9(lo)};
    endfunction

    assign data_out = {col(encrypt, data_in[15:8]), col(encrypt, data_in[7:0])};

endmodule

module s_aes_iter_ctrl #(
    parameter int KEY_CACHE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] data_in,
    input  logic [15:0] key_in,
    input  logic        encrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] data_out,
    output logic        busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_KEY1 = 3'd1;
    localparam logic [2:0] S_KEY2 = 3'd2;
    localparam logic [2:0] S_ADD0 = 3'd3;
    localparam logic [2:0] S_RND1 = 3'd4;
    localparam logic [2:0] S_RND2 = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]  state;
    logic [15:0] st;
    logic [15:0] k0;
    logic [15:0] k1;
    logic [15:0] k2;
    logic        dir;
    logic        cache_valid;

    logic        hit;
    logic [7:0]  w2;
    logic [7:0]  w3;
    logic [7:0]  w4;
    logic [7:0]  w5;
    logic [15:0] mc_in;
    logic [15:0] mc_out;
    logic [15:0] rnd1;
    logic [15:0] rnd2;

    function automatic logic [3:0] ns(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'h9;
            4'h1: y = 4'h4;
            4'h2: y = 4'hA;
            4'h3: y = 4'hB;
            4'h4: y = 4'hD;
            4'h5: y = 4'h1;
            4'h6: y = 4'h8;
            4'h7: y = 4'h5;
            4'h8: y = 4'h6;
            4'h9: y = 4'h2;
            4'hA: y = 4'h0;
            4'hB: y = 4'h3;
            4'hC: y = 4'hC;
            4'hD: y = 4'hE;
            4'hE: y = 4'hF;
            default: y = 4'h7;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] ins(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hA;
            4'h1: y = 4'h5;
            4'h2: y = 4'h9;
            4'h3: y = 4'hB;
            4'h4: y = 4'h1;
            4'h5: y = 4'h7;
            4'h6: y = 4'h8;
            4'h7: y = 4'hF;
            4'h8: y = 4'h6;
            4'h9: y = 4'h0;
            4'hA: y = 4'h2;
            4'hB: y = 4'h3;
            4'hC: y = 4'hC;
            4'hD: y = 4'h4;
            4'hE: y = 4'hD;
            default: y = 4'hE;
        endcase
        return y;
    endfunction

    function automatic logic [15:0] nsub(input logic [15:0] w);
        return {ns(w[15:12]), ns(w[11:8]), ns(w[7:4]), ns(w[3:0])};
    endfunction

    function automatic logic [15:0] insub(input logic [15:0] w);
        return {ins(w[15:12]), ins(w[11:8]), ins(w[7:4]), ins(w[3:0])};
    endfunction

    function automatic logic [15:0] sr(input logic [15:0] w);
        return {w[15:12], w[3:0], w[7:4], w[11:8]};
    endfunction

    // NS(RotNib(b)): rotate the byte's nibbles, then substitute each.
    function automatic logic [7:0] subrot(input logic [7:0] b);
        return {ns(b[3:0]), ns(b[7:4])};
    endfunction

    assign hit = (KEY_CACHE != 0) && cache_valid && (key_in == k0);

    assign w2 = k0[15:8] ^ 8'h80 ^ subrot(k0[7:0]);
    assign w3 = w2 ^ k0[7:0];
    assign w4 = k1[15:8] ^ 8'h30 ^ subrot(k1[7:0]);
    assign w5 = w4 ^ k1[7:0];

    // Single mix_columns; its direction is the latched dir so the
    // encrypt and decrypt round-1 paths share it.
    assign mc_in = dir ? sr(nsub(st)) : (insub(sr(st)) ^ k1);
    assign rnd1  = dir ? (mc_out ^ k1) : mc_out;
    assign rnd2  = dir ? (sr(nsub(st)) ^ k2) : (insub(sr(st)) ^ k0);

    mix_columns u_mix (
        .encrypt  (dir),
        .data_in  (mc_in),
        .data_out (mc_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            st          <= 16'h0;
            k0          <= 16'h0;
            k1          <= 16'h0;
            k2          <= 16'h0;
            dir         <= 1'b0;
            cache_valid <= 1'b0;
            data_out    <= 16'h0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        st    <= data_in;
                        k0    <= key_in;
                        dir   <= encrypt;
                        state <= hit ? S_ADD0 : S_KEY1;
                    end
                end
                S_KEY1: begin
                    k1    <= {w2, w3};
                    state <= S_KEY2;
                end
                S_KEY2: begin
                    k2          <= {w4, w5};
                    cache_valid <= 1'b1;
                    state       <= S_ADD0;
                end
                S_ADD0: begin
                    st    <= st ^ (dir ? k0 : k2);
                    state <= S_RND1;
                end
                S_RND1: begin
                    st    <= rnd1;
                    state <= S_RND2;
                end
                S_RND2: begin
                    st       <= rnd2;
                    data_out <= rnd2;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);

endmodule

// File: doc/s_aes_iter_ctrl.md
Name: s_aes_iter_ctrl

Overview:
- Iterative S-AES encrypt/decrypt controller for one 16-bit block at a time.
- Accepts block, key and direction over a valid/ready handshake, expands the key internally and sequences a single shared round datapath (nibble-sub, shift-rows, mix_columns, add-round-key) through the 2-round schedule.
- Holds the result until it is accepted.
- Sits between the top-level I/O wrapper and the existing mix_columns block; instantiates exactly one mix_columns, driven by its Encrypt input.

Parameters:
- KEY_CACHE, 1: when 1, K1/K2 are reused if the new key equals the last expanded key (key-expansion states skipped); when 0, every block expands the key.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request: data_in/key_in/encrypt valid.
- in_ready  out  1  high only in IDLE; a transfer occurs when in_valid && in_ready.
- data_in  in  16  plaintext (encrypt=1) or ciphertext (encrypt=0).
- key_in  in  16  cipher key K0.
- encrypt  in  1  1 = encrypt, 0 = decrypt; latched at transfer.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accept.
- data_out  out  16  result; stable while out_valid=1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Nibble order: n0=[15:12], n1=[11:8], n2=[7:4], n3=[3:0].
- SR: swaps n1 and n3; it is its own inverse.
- NS: S-box 0..F -> 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7.
- INS: inverse of NS.
- MC/IMC: mix_columns with Encrypt=1/0, applied to the whole 16-bit word.
- Key expansion: w0=K0[15:8], w1=K0[7:0].
  - w2 = w0 ^ 0x80 ^ NS(RotNib(w1)); w3 = w2 ^ w1.
  - w4 = w2 ^ 0x30 ^ NS(RotNib(w3)); w5 = w4 ^ w3.
  - RotNib swaps the two nibbles of a byte. K1 = {w2,w3}, K2 = {w4,w5}.
- FSM states: IDLE, KEY1, KEY2, ADD0, RND1, RND2, DONE.
- IDLE:
  - On transfer, latch st=data_in, K0=key_in, dir=encrypt.
  - Next state is ADD0 if KEY_CACHE=1, cache_valid=1 and key_in equals the cached K0; otherwise KEY1.
- KEY1: register K1 -> KEY2.
- KEY2: register K2; set cache_valid=1 -> ADD0.
- ADD0: st ^= (dir ? K0 : K2) -> RND1.
- RND1:
  - Encrypt: st = MC(SR(NS(st))) ^ K1.
  - Decrypt: st = IMC(INS(SR(st)) ^ K1).
  - Next: RND2.
- RND2:
  - Encrypt: st = SR(NS(st)) ^ K2.
  - Decrypt: st = INS(SR(st)) ^ K0.
  - Next: DONE.
- DONE:
  - out_valid=1, data_out=st.
  - If out_ready -> IDLE; otherwise stay, with data_out frozen.
- Latency from the transfer edge to out_valid rising: 5 cycles (full key expansion) or 3 cycles (cache hit).
- No same-cycle accept on the DONE->IDLE transition: in_ready rises the cycle after the result is accepted.
- in_valid is ignored while busy=1. Input changes after transfer have no effect.
- data_out is a registered copy of st, updated only on the RND2->DONE transition.
- Reset (asynchronous, any state, including mid-round):
  - State -> IDLE; st, K0, K1, K2, data_out = 0; cache_valid = 0.
  - Outputs: out_valid=0, busy=0, in_ready=1 (combinational from IDLE).
- The mix_columns instance is shared across directions; its Encrypt input equals dir, so it changes only on transfer.
- Cached key compare uses the full 16 bits. cache_valid is cleared only by reset.

Test Plan:
- Encrypt vector: rst pulse, then data_in=0x6F6B, key_in=0xA73B, encrypt=1 -> out_valid 5 cycles after transfer, data_out=0x0738; internal K1=0x1C27, K2=0x7651.
- Decrypt plus cache hit: next, data_in=0x0738, same key, encrypt=0 with KEY_CACHE=1 -> out_valid 3 cycles after transfer, data_out=0x6F6B.
- Second vector and cache miss: data_in=0xD728, key_in=0x4AF5, encrypt=1 -> latency 5, data_out=0x24EC. Decrypting 0x24EC with the same key -> 0xD728.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, data_out constant, in_ready=0; in_valid pulses are ignored. out_ready=1 -> IDLE, and in_ready=1 on the following cycle.
- Reset mid-operation: assert rst during RND1 -> out_valid=0, busy=0, data_out=0 immediately (asynchronously). The next identical key then takes latency 5 (cache cleared).
- KEY_CACHE=0 build: repeat scenario 2 -> latency 5, same data_out=0x6F6B.
